aes_round_ctrl: RTL and testbench
=================================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter BYTE, default 8, SHALL be the byte width in bits.
REQ-002 Parameter LENGTH, default 128, SHALL be the AES state/block width in bits.
REQ-003 Parameter ROUNDS, default 10, SHALL be the number of cipher rounds after the initial AddRoundKey (AES-128).
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-006 flush  input  1  SHALL be a synchronous abort, returning the block to its reset state.
REQ-007 in_valid  input  1  SHALL flag that in_data is valid (plaintext block).
REQ-008 in_ready  output  1  SHALL flag that the block can accept a plaintext.
REQ-009 in_data  input  LENGTH  SHALL be the plaintext block.
REQ-010 rk_idx  output  4  SHALL select the round key the external key store presents on rk.
REQ-011 rk  input  LENGTH  SHALL be the round key for rk_idx, combinational from the key store.
REQ-012 dp_state  output  LENGTH  SHALL drive the internal state register to the external round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey).
REQ-013 dp_last  output  1  SHALL tell the datapath to bypass MixColumns (final round).
REQ-014 dp_result  input  LENGTH  SHALL be the combinational round result from the datapath.
REQ-015 out_valid  output  1  SHALL flag that out_data holds a finished ciphertext.
REQ-016 out_ready  input  1  SHALL flag that the consumer takes out_data.
REQ-017 out_data  output  LENGTH  SHALL be the ciphertext, equal to the state register.
REQ-018 busy  output  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-020 IDLE: in_ready=1, rk_idx=0, dp_last=0; on in_valid=1 the state register SHALL load in_data XOR rk, the round counter SHALL load 1, and the FSM SHALL go to RUN.
REQ-021 RUN: in_ready=0, rk_idx=round counter, dp_last=(round==ROUNDS); each edge SHALL load dp_result into the state register.
REQ-022 RUN with round<ROUNDS SHALL increment the round counter (4-bit, no wrap is reachable); with round==ROUNDS the FSM SHALL go to DONE.
REQ-023 DONE: out_valid=1, in_ready=0, state register held; on out_ready=1 the FSM SHALL go to IDLE; no new block is accepted in that same cycle.
REQ-024 out_valid SHALL first be high in the ROUNDS-th cycle after the accept edge (first ciphertext visible 10 cycles after acceptance); throughput is one block per ROUNDS+2 cycles with out_ready held high.
REQ-025 out_data SHALL be stable for as long as out_valid=1 and out_ready=0 (backpressure, unbounded).
REQ-026 in_valid/in_data SHALL be ignored outside IDLE; dp_result SHALL be ignored outside RUN.
REQ-027 flush=1 SHALL take priority over every other event, including a same-cycle accept or out_ready, and SHALL force reset values at the next edge.
REQ-028 rk_idx in DONE SHALL read ROUNDS; dp_last SHALL be 0 outside RUN.

Reset
REQ-029 rst_n=0 SHALL immediately force FSM=IDLE, round counter=0, state register=0, out_valid=0, busy=0, in_ready=1.
REQ-030 rst_n deassertion SHALL be synchronised by the integrator; the block SHALL operate from the first edge with rst_n=1.
REQ-031 Reset mid-RUN or in DONE SHALL discard the block in progress with no out_valid pulse.

Verification
REQ-032 Stub datapath dp_result=dp_state^rk, rk={124'h0,rk_idx}; in_data=128'hFF, in_valid one cycle -> out_valid exactly 10 cycles after accept, out_data=128'hF4, rk_idx sequence 0,1..10.
REQ-033 Real datapath plus key store, key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a; dp_last high only in round 10.
REQ-034 Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid and out_data stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-035 Back-to-back: in_valid held high with out_ready=1 -> accepts every 12 cycles, no block lost or duplicated.
REQ-036 flush at round 5 with in_valid=1 -> next cycle IDLE, busy=0, out_valid never asserted; the next block then completes normally.
REQ-037 rst_n pulsed low asynchronously mid-RUN -> outputs reset immediately (before the next edge), state register=0.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES-128 encryptor: owns the state register and round
// counter, steps an external round datapath and key store, and hands off the ciphertext.
module aes_round_ctrl #(
    parameter int BYTE   = 8,
    parameter int LENGTH = 128,
    parameter int ROUNDS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] in_data,
    output logic [3:0]        rk_idx,
    input  logic [LENGTH-1:0] rk,
    output logic [LENGTH-1:0] dp_state,
    output logic              dp_last,
    input  logic [LENGTH-1:0] dp_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] out_data,
    output logic              busy
);

    localparam int          NBYTES     = LENGTH / BYTE;
    localparam logic [3:0]  LAST_ROUND = 4'(ROUNDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e              fsm_q, fsm_d;
    logic [3:0]          round_q, round_d;
    logic [LENGTH-1:0]   state_q, state_d;
    logic [LENGTH-1:0]   init_blk;

    // Initial AddRoundKey with round key 0, applied as the plaintext is captured.
    for (genvar gb = 0; gb < NBYTES; gb++) begin : g_init_ark
        assign init_blk[gb*BYTE +: BYTE] = in_data[gb*BYTE +: BYTE] ^ rk[gb*BYTE +: BYTE];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = init_blk;
                    round_d = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = dp_result;
                if (round_q == LAST_ROUND) fsm_d = DONE;
                else                       round_d = round_q + 4'd1;
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d   = IDLE;
                    round_d = 4'd0;
                end
            end
            default: fsm_d = IDLE;
        endcase
        // Abort wins over accept, round step and hand-off alike.
        if (flush) begin
            fsm_d   = IDLE;
            round_d = 4'd0;
            state_d = '0;
        end
    end

    always_comb begin
        rk_idx = 4'd0;
        case (fsm_q)
            RUN:     rk_idx = round_q;
            DONE:    rk_idx = LAST_ROUND;
            default: rk_idx = 4'd0;
        endcase
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign out_valid = (fsm_q == DONE);
    assign dp_last   = (fsm_q == RUN) && (round_q == LAST_ROUND);
    assign dp_state  = state_q;
    assign out_data  = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: a behavioural key store and toy round datapath around the DUT,
// with expected ciphertexts computed by iterating the round recurrence directly.
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, in_ready, dp_last, out_valid, out_ready, busy;
    logic [127:0] in_data, rk, dp_state, dp_result, out_data;
    logic [3:0]   rk_idx;

    logic [127:0] key [16];
    logic         stub;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    // Stub mode: rk is the index itself and a round is a plain XOR.
    // Keyed mode: random keys, and every round but the last rotates the state left by one.
    assign rk        = stub ? {124'h0, rk_idx} : key[rk_idx];
    assign dp_result = stub ? (dp_state ^ rk)
                            : ((dp_last ? dp_state : {dp_state[126:0], dp_state[127]}) ^ rk);

    aes_round_ctrl #(.BYTE(8), .LENGTH(128), .ROUNDS(10)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rk_idx(rk_idx), .rk(rk),
        .dp_state(dp_state), .dp_last(dp_last), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] key_of(input int r);
        return stub ? 128'(r) : key[r];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] din);
        logic [127:0] s;
        s = din ^ key_of(0);
        for (int r = 1; r <= 10; r++)
            s = ((stub || r == 10) ? s : {s[126:0], s[127]}) ^ key_of(r);
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic new_keys();
        for (int i = 0; i < 16; i++) key[i] = rnd128();
    endtask

    // One block: accept, step through the rounds, hold under backpressure, hand off.
    task automatic run_block(input logic [127:0] din, input logic [127:0] exp, input int bp);
        int lat;
        chk("idle_in_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_data  = din;
        out_ready = 1'b0;
        tick();
        lat = 0;
        while (!out_valid && lat < 30) begin
            chk("rk_idx_seq", 128'(rk_idx), 128'(lat + 1));
            chk("dp_last", 128'(dp_last), 128'(rk_idx == 4'd10));
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rnd128();
            tick();
            lat++;
        end
        chk("latency", 128'(lat), 128'(10));
        chk("out_data", out_data, exp);
        chk("done_rk_idx", 128'(rk_idx), 128'(10));
        chk("done_flags", 128'({in_ready, busy, dp_last}), 128'(3'b010));
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_hold", {out_data[126:0], out_valid}, {exp[126:0], 1'b1});
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = rnd128();
        tick();
        chk("handoff_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] exp_q[$];
        logic [127:0] d, e;
        int acc_cyc[$];
        int cyc, gap_bad, ov_seen;

        stub = 1'b1;
        new_keys();
        flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_flags", 128'({in_ready, busy, out_valid, dp_last}), 128'(4'b1000));
        chk("rst_state", out_data, 128'h0);
        chk("rst_rk_idx", 128'(rk_idx), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed stub vector: 0xFF ^ (0^1^..^10) = 0xF4.
        run_block(128'hFF, 128'hF4, 3);

        // Random keyed blocks with random backpressure, one with a long stall.
        stub = 1'b0;
        for (int b = 0; b < 10; b++) begin
            new_keys();
            d = rnd128();
            run_block(d, model(d), (b == 4) ? 20 : $urandom_range(0, 5));
        end

        // Back-to-back with in_valid and out_ready held high.
        new_keys();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        gap_bad = 0;
        for (cyc = 0; cyc < 80; cyc++) begin
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                chk("b2b_data", out_data, e);
            end
            in_data = rnd128();
            if (in_ready) begin
                exp_q.push_back(model(in_data));
                acc_cyc.push_back(cyc);
            end
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
            if (out_valid) chk("b2b_drain", out_data, exp_q.pop_front());
            tick();
        end
        chk("b2b_left", 128'(exp_q.size()), 128'(0));
        chk("b2b_count", 128'(acc_cyc.size()), 128'(7));
        for (int i = 1; i < acc_cyc.size(); i++)
            if (acc_cyc[i] - acc_cyc[i-1] != 12) gap_bad++;
        chk("b2b_spacing", 128'(gap_bad), 128'(0));
        out_ready = 1'b0;
        tick();

        // Flush at round 5 with a competing in_valid.
        d = rnd128();
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && rk_idx != 4'd5; i++) tick();
        chk("flush_at_r5", 128'(rk_idx), 128'(5));
        flush = 1'b1; in_valid = 1'b1; in_data = rnd128(); out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_flags", 128'({in_ready, busy, out_valid}), 128'(3'b100));
        chk("flush_state", out_data, 128'h0);
        chk("flush_rk_idx", 128'(rk_idx), 128'(0));
        ov_seen = 0;
        for (int i = 0; i < 14; i++) begin
            if (out_valid) ov_seen++;
            tick();
        end
        chk("flush_no_out", 128'(ov_seen), 128'(0));
        d = rnd128();
        run_block(d, model(d), 1);

        // Asynchronous reset mid-RUN.
        d = rnd128();
        in_valid = 1'b1; in_data = d;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_flags", 128'({in_ready, busy, out_valid, dp_last}), 128'(4'b1000));
        chk("arst_state", out_data, 128'h0);
        chk("arst_rk_idx", 128'(rk_idx), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (out_valid) ov_seen++;
        end
        chk("arst_no_out", 128'(ov_seen), 128'(0));
        d = rnd128();
        run_block(d, model(d), 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
